// File: rtl/pipelined_barrel_shifter_if.sv
// Stream interface for the pipelined barrel shifter: the operand stream in
// and the result stream out, each with a valid/ready handshake.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 8
);
  localparam int SH_W = $clog2(WIDTH);

  // operand stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SH_W-1:0]  in_shamt;
  logic [1:0]       in_mode;

  // result stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;

  // producer of operands and consumer of results
  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  // the shifter itself
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter. One register stage per shift-amount bit: stage k
// shifts by 2^k when bit k of the shift amount is set. Four modes (LSR, ASR,
// LSL, ROR), valid/ready on both sides with a per-stage ready chain so that
// bubbles collapse and throughput is one operation per clock.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      flush,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end

  // Shift d by n positions in mode m. For ASR the fill bit is the current MSB:
  // every earlier stage either left the operand alone or already replicated
  // its sign, so the MSB seen here is always the original operand MSB.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input int unsigned      n,
    input logic [1:0]       m
  );
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> n);
    case (m)
      MODE_LSR: shift_level = d >> n;
      MODE_ASR: shift_level = (d >> n) | (d[WIDTH-1] ? fill : {WIDTH{1'b0}});
      MODE_LSL: shift_level = d << n;
      MODE_ROR: shift_level = (d >> n) | (d << (WIDTH - n));
      default:  shift_level = d;
    endcase
  endfunction

  // stage registers
  logic [SH_W-1:0]  valid_r;
  logic [WIDTH-1:0] data_r  [SH_W];
  logic [SH_W-1:0]  shamt_r [SH_W];
  logic [1:0]       mode_r  [SH_W];

  // stage inputs (what each stage would capture) and the ready chain
  logic [SH_W-1:0]  vin_s;
  logic [WIDTH-1:0] din_s     [SH_W];
  logic [SH_W-1:0]  sin_s     [SH_W];
  logic [1:0]       min_s     [SH_W];
  logic [WIDTH-1:0] shifted_s [SH_W];
  logic [SH_W-1:0]  ready_s;

  // Ready chain from the output back to the input: a stage can take new
  // content when it is empty or its content moves on this cycle.
  always_comb begin
    logic chain;
    ready_s = {SH_W{1'b0}};
    chain   = bus.out_ready;
    for (int k = SH_W - 1; k >= 0; k--) begin
      chain      = !valid_r[k] || chain;
      ready_s[k] = chain;
    end
  end

  // Route each stage's input (input port for stage 0, previous stage
  // otherwise) and apply that stage's conditional 2^k shift.
  always_comb begin
    vin_s[0] = bus.in_valid;
    din_s[0] = bus.in_data;
    sin_s[0] = bus.in_shamt;
    min_s[0] = bus.in_mode;
    for (int k = 1; k < SH_W; k++) begin
      vin_s[k] = valid_r[k-1];
      din_s[k] = data_r[k-1];
      sin_s[k] = shamt_r[k-1];
      min_s[k] = mode_r[k-1];
    end
    for (int k = 0; k < SH_W; k++) begin
      if (sin_s[k][k]) begin
        shifted_s[k] = shift_level(din_s[k], 32'd1 << k, min_s[k]);
      end else begin
        shifted_s[k] = din_s[k];
      end
    end
  end

  // Pipeline registers: flush empties every stage; otherwise a ready stage
  // takes its input, loading the payload only when the input is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {SH_W{1'b0}};
      for (int k = 0; k < SH_W; k++) begin
        data_r[k]  <= {WIDTH{1'b0}};
        shamt_r[k] <= {SH_W{1'b0}};
        mode_r[k]  <= 2'b00;
      end
    end else if (flush) begin
      valid_r <= {SH_W{1'b0}};
    end else begin
      for (int k = 0; k < SH_W; k++) begin
        if (ready_s[k]) begin
          valid_r[k] <= vin_s[k];
          if (vin_s[k]) begin
            data_r[k]  <= shifted_s[k];
            shamt_r[k] <= sin_s[k];
            mode_r[k]  <= min_s[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = ready_s[0];
  assign bus.out_valid = valid_r[SH_W-1];
  assign bus.out_data  = data_r[SH_W-1];
  assign bus.out_mode  = mode_r[SH_W-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): directed mode,
// boundary, backpressure, flush and reset scenarios plus a randomized stream,
// all checked against a scoreboard fed from an arithmetic reference model.
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 8;
  localparam int SH_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    int         acc;
  } item_t;

  item_t      q[$];
  item_t      it;
  int         tests     = 0;
  int         fails     = 0;
  int         cyc       = 0;
  int         last_low  = -1;
  int         out_xfers = 0;
  bit         front_seen = 1'b0;
  bit         prev_hold  = 1'b0;
  logic [7:0] prev_data;
  logic [1:0] prev_mode;
  bit         rand_phase = 1'b0;
  logic [7:0] pin_exp [4];

  // reference: plain arithmetic on the operand
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] m);
    logic signed [7:0] sd;
    logic [15:0]       dd;
    case (m)
      2'd0: return d >> s;
      2'd1: begin sd = d; sd = sd >>> s; return sd; end
      2'd2: return d << s;
      default: begin dd = {d, d} >> s; return dd[7:0]; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // compare process: runs every negedge, scores handshakes on both sides
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        front_seen = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", bus.out_valid, 1'b1);
          chk("hold_data",  bus.out_data,  prev_data);
          chk("hold_mode",  bus.out_mode,  prev_mode);
        end
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_result", bus.out_valid, 1'b0);
          end else begin
            chk("out_data", bus.out_data, q[0].data);
            chk("out_mode", bus.out_mode, q[0].mode);
            if (!front_seen) begin
              front_seen = 1'b1;
              if (q[0].acc > last_low)
                chk("latency", cyc - q[0].acc, SH_W);
              else
                chk("latency_min", (cyc - q[0].acc) >= SH_W, 1'b1);
            end
            if (bus.out_ready) begin
              void'(q.pop_front());
              front_seen = 1'b0;
              out_xfers++;
            end
          end
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        prev_mode = bus.out_mode;
        if (!bus.out_ready) last_low = cyc;
        if (flush) begin
          q.delete();
          front_seen = 1'b0;
          prev_hold  = 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
          it.data = ref_shift(bus.in_data, int'(bus.in_shamt), bus.in_mode);
          it.mode = bus.in_mode;
          it.acc  = cyc;
          q.push_back(it);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !flush && rst_n) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", bus.in_ready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(8'($urandom()), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
  endtask

  // one op on an idle pipe: result must appear exactly 3 cycles later
  task automatic single_op(input string name, input logic [7:0] d, input logic [2:0] s,
                           input logic [1:0] m, input logic [7:0] exp);
    bit got = 1'b0;
    send(d, s, m);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk({name, "_lat"},  k, SH_W);
        chk({name, "_data"}, bus.out_data, exp);
        chk({name, "_mode"}, bus.out_mode, m);
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_timeout"}, bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_shamt  = 3'd0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b1;

    // pin the reference model with hand-computed values
    pin_exp[0] = 8'h16; pin_exp[1] = 8'hF6; pin_exp[2] = 8'hA0; pin_exp[3] = 8'h96;
    for (int m = 0; m < 4; m++) chk("model_b4_sh3", ref_shift(8'hB4, 3, 2'(m)), pin_exp[m]);
    chk("model_asr7", ref_shift(8'h80, 7, 2'd1), 8'hFF);
    chk("model_lsr7", ref_shift(8'h80, 7, 2'd0), 8'h01);
    chk("model_lsl7", ref_shift(8'h01, 7, 2'd2), 8'h80);
    chk("model_ror1", ref_shift(8'h01, 1, 2'd3), 8'h80);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data",  bus.out_data,  8'h00);
    chk("rst_out_mode",  bus.out_mode,  2'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("idle_out_valid", bus.out_valid, 1'b0);

    // modes on 0xB4 >> 3
    for (int m = 0; m < 4; m++) single_op("mode_b4", 8'hB4, 3'd3, 2'(m), pin_exp[m]);

    // boundaries
    single_op("asr7", 8'h80, 3'd7, 2'd1, 8'hFF);
    single_op("lsr7", 8'h80, 3'd7, 2'd0, 8'h01);
    single_op("lsl7", 8'h01, 3'd7, 2'd2, 8'h80);
    single_op("ror1", 8'h01, 3'd1, 2'd3, 8'h80);
    for (int m = 0; m < 4; m++) single_op("shamt0", 8'hA5, 3'd0, 2'(m), 8'hA5);

    // back-to-back: 16 ops, 16 results
    begin
      int x0;
      x0 = out_xfers;
      for (int i = 0; i < 16; i++) send_rand();
      repeat (8) @(posedge clk);
      #1;
      chk("b2b_count", out_xfers - x0, 16);
    end

    // backpressure: three ops fill the pipe, the fourth waits
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    bus.in_shamt = 3'd5;
    bus.in_mode  = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'hC3, 3'd5, 2'd1);
    send_rand();
    send_rand();
    drain();

    // flush with three ops in flight and out_ready low
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_shamt = 3'd1;
    bus.in_mode  = 2'd2;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready",  bus.in_ready,  1'b1);
    bus.out_ready = 1'b1;
    single_op("after_flush", 8'h3C, 3'd2, 2'd2, 8'hF0);
    repeat (5) @(posedge clk);
    #1;
    chk("after_flush_empty", q.size(), 0);

    // reset pulse mid-stream
    bus.out_ready = 1'b0;
    send(8'h5A, 3'd0, 2'd2);
    send(8'h5A, 3'd4, 2'd3);
    send(8'h77, 3'd2, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_data",  bus.out_data,  8'h00);
    chk("arst_out_mode",  bus.out_mode,  2'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", bus.in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("arst_no_stale", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    single_op("after_rst", 8'h96, 3'd4, 2'd0, 8'h09);

    // randomized stream with random bubbles and random backpressure
    rand_phase = 1'b1;
    fork
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    rand_phase = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
